// File: rtl/cd_dma_engine_if.sv
// Bus-side signals of the CD DMA engine: 68k bus arbitration (BR/BG/BGACK) plus a word-wide memory port.
// Latency: wires only, no storage.
// Backpressure: the memory stalls the engine by withholding MEM_RDY; the arbiter stalls it by withholding BUS_GNT.
//
// master : the DMA engine (drives BUS_REQ/BUS_ACK, address, write data and strobes)
// slave  : arbiter + memory (drives BUS_GNT, MEM_RDATA, MEM_RDY)
interface cd_dma_engine_if;
    logic        BUS_REQ;
    logic        BUS_GNT;
    logic        BUS_ACK;
    logic [22:0] MEM_ADDR;   // word address, byte address bits [23:1]
    logic [15:0] MEM_WDATA;
    logic [15:0] MEM_RDATA;
    logic        MEM_RD;
    logic        MEM_WR;
    logic        MEM_RDY;

    modport master (
        output BUS_REQ, BUS_ACK, MEM_ADDR, MEM_WDATA, MEM_RD, MEM_WR,
        input  BUS_GNT, MEM_RDATA, MEM_RDY
    );

    modport slave (
        input  BUS_REQ, BUS_ACK, MEM_ADDR, MEM_WDATA, MEM_RD, MEM_WR,
        output BUS_GNT, MEM_RDATA, MEM_RDY
    );
endinterface

// File: rtl/cd_dma_engine.sv
// CD DMA engine: word fill or word copy over the 68k bus after acquiring it through BR/BG/BGACK.
// Latency: with MEM_RDY returned immediately, 2 clocks per word for fill, 3 clocks per word for copy.
// Backpressure: strobes are held until MEM_RDY; grant is awaited in REQ; abort only acts between words.
//
// Ports: CLK_68KCLK (all state changes on its falling edge), nRESET (async, active-low),
//        DMA_START/DMA_MODE/DMA_SOURCE/DMA_DEST/DMA_VALUE/DMA_COUNT/DMA_ABORT configuration and control,
//        DMA_BUSY (combinational, state != IDLE), DMA_DONE (one-cycle pulse on return to IDLE),
//        bus : arbitration and memory port (master side).
module cd_dma_engine #(
    parameter int CNT_W = 20
) (
    input  logic             CLK_68KCLK,
    input  logic             nRESET,
    input  logic             DMA_START,
    input  logic             DMA_MODE,
    input  logic [23:0]      DMA_SOURCE,
    input  logic [23:0]      DMA_DEST,
    input  logic [15:0]      DMA_VALUE,
    input  logic [CNT_W-1:0] DMA_COUNT,
    input  logic             DMA_ABORT,
    output logic             DMA_BUSY,
    output logic             DMA_DONE,
    cd_dma_engine_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_READ,
        ST_WRITE,
        ST_NEXT,
        ST_RELEASE
    } state_t;

    state_t           state;
    logic             mode_copy;
    logic [22:0]      src_wa;
    logic [22:0]      dst_wa;
    logic [15:0]      fill_val;
    logic [CNT_W-1:0] word_cnt;

    logic [22:0]      src_inc;
    logic [22:0]      dst_inc;
    logic [CNT_W-1:0] cnt_dec;
    logic             addr_lsb_unused;

    // Word addresses are 23 bits wide, so the increment wraps modulo 2^23 words on its own.
    assign src_inc  = src_wa + 23'd1;
    assign dst_inc  = dst_wa + 23'd1;
    assign cnt_dec  = word_cnt - CNT_W'(1);
    assign DMA_BUSY = (state != ST_IDLE);

    // Byte-address bit 0 has no meaning on a word bus.
    assign addr_lsb_unused = DMA_SOURCE[0] ^ DMA_DEST[0];

    always_ff @(negedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            state         <= ST_IDLE;
            mode_copy     <= 1'b0;
            src_wa        <= '0;
            dst_wa        <= '0;
            fill_val      <= '0;
            word_cnt      <= '0;
            bus.BUS_REQ   <= 1'b0;
            bus.BUS_ACK   <= 1'b0;
            bus.MEM_ADDR  <= '0;
            bus.MEM_WDATA <= '0;
            bus.MEM_RD    <= 1'b0;
            bus.MEM_WR    <= 1'b0;
            DMA_DONE      <= 1'b0;
        end else begin
            DMA_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A start that coincides with abort is dropped.
                    if (DMA_START && !DMA_ABORT) begin
                        mode_copy <= DMA_MODE;
                        src_wa    <= DMA_SOURCE[23:1];
                        dst_wa    <= DMA_DEST[23:1];
                        fill_val  <= DMA_VALUE;
                        word_cnt  <= DMA_COUNT;
                        if (DMA_COUNT == '0) begin
                            state <= ST_RELEASE;
                        end else begin
                            state       <= ST_REQ;
                            bus.BUS_REQ <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (DMA_ABORT) begin
                        bus.BUS_REQ <= 1'b0;
                        state       <= ST_RELEASE;
                    end else if (bus.BUS_GNT) begin
                        bus.BUS_REQ <= 1'b0;
                        bus.BUS_ACK <= 1'b1;
                        if (mode_copy) begin
                            state        <= ST_READ;
                            bus.MEM_RD   <= 1'b1;
                            bus.MEM_ADDR <= src_wa;
                        end else begin
                            state         <= ST_WRITE;
                            bus.MEM_WR    <= 1'b1;
                            bus.MEM_ADDR  <= dst_wa;
                            bus.MEM_WDATA <= fill_val;
                        end
                    end
                end
                ST_READ: begin
                    // MEM_WDATA doubles as the data holding register between read and write.
                    if (bus.MEM_RDY) begin
                        state         <= ST_WRITE;
                        bus.MEM_RD    <= 1'b0;
                        bus.MEM_WR    <= 1'b1;
                        bus.MEM_ADDR  <= dst_wa;
                        bus.MEM_WDATA <= bus.MEM_RDATA;
                    end
                end
                ST_WRITE: begin
                    if (bus.MEM_RDY) begin
                        state      <= ST_NEXT;
                        bus.MEM_WR <= 1'b0;
                    end
                end
                ST_NEXT: begin
                    if (mode_copy) begin
                        src_wa <= src_inc;
                    end
                    dst_wa   <= dst_inc;
                    word_cnt <= cnt_dec;
                    // Abort is only honoured here, between words, so no access is ever cut short.
                    if (cnt_dec == '0 || DMA_ABORT) begin
                        state <= ST_RELEASE;
                    end else if (mode_copy) begin
                        state        <= ST_READ;
                        bus.MEM_RD   <= 1'b1;
                        bus.MEM_ADDR <= src_inc;
                    end else begin
                        state         <= ST_WRITE;
                        bus.MEM_WR    <= 1'b1;
                        bus.MEM_ADDR  <= dst_inc;
                        bus.MEM_WDATA <= fill_val;
                    end
                end
                ST_RELEASE: begin
                    bus.BUS_REQ <= 1'b0;
                    bus.BUS_ACK <= 1'b0;
                    bus.MEM_RD  <= 1'b0;
                    bus.MEM_WR  <= 1'b0;
                    DMA_DONE    <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cd_dma_engine.sv
// Bench for cd_dma_engine: arbiter + memory environment, access-list reference model, per-cycle compare.
// Inputs change and outputs are sampled around the rising edge, away from the active falling edge.
// The reference model lists every memory access a transfer must make, in order, from the configuration.
module tb_cd_dma_engine;

    typedef struct packed {
        logic        wr;
        logic [22:0] addr;
        logic [15:0] data;
    } acc_t;

    logic        clk = 1'b0;
    logic        nRESET;
    logic        DMA_START;
    logic        DMA_MODE;
    logic [23:0] DMA_SOURCE;
    logic [23:0] DMA_DEST;
    logic [15:0] DMA_VALUE;
    logic [19:0] DMA_COUNT;
    logic        DMA_ABORT;
    logic        DMA_BUSY;
    logic        DMA_DONE;
    logic        abort_drv;
    logic        abort_latch = 1'b0;

    cd_dma_engine_if bus();

    cd_dma_engine #(.CNT_W(20)) dut (
        .CLK_68KCLK (clk),
        .nRESET     (nRESET),
        .DMA_START  (DMA_START),
        .DMA_MODE   (DMA_MODE),
        .DMA_SOURCE (DMA_SOURCE),
        .DMA_DEST   (DMA_DEST),
        .DMA_VALUE  (DMA_VALUE),
        .DMA_COUNT  (DMA_COUNT),
        .DMA_ABORT  (DMA_ABORT),
        .DMA_BUSY   (DMA_BUSY),
        .DMA_DONE   (DMA_DONE),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    assign DMA_ABORT = abort_drv | abort_latch;

    int   errs = 0;
    int   checks = 0;
    acc_t exp_q[$];
    acc_t log_q[$];
    int   gnt_lat = 0, mem_lat = 0, abort_k = 0;
    int   gnt_wait = 0, mem_wait = 0, wr_cnt = 0;
    int   done_cnt = 0, busy_cycles = 0, cyc = 0, start_cyc = -1, done_cyc = -1;
    bit   req_seen = 0, ack_seen = 0;

    // Contents of the simulated source memory at a word address.
    function automatic logic [15:0] rd_pat(input logic [22:0] a);
        return a[15:0] ^ {a[22:16], 9'h15A};
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Environment: arbiter with programmable grant delay, memory with programmable RDY delay,
    // and abort injection during the abort_k-th write.
    always @(posedge clk) begin
        if (!nRESET) begin
            bus.BUS_GNT   = 1'b0;
            bus.MEM_RDY   = 1'b0;
            bus.MEM_RDATA = 16'hDEAD;
            gnt_wait      = 0;
            mem_wait      = 0;
            abort_latch   = 1'b0;
        end else begin
            if (abort_k == 0) abort_latch = 1'b0;
            else if (bus.MEM_WR && wr_cnt == abort_k - 1) abort_latch = 1'b1;

            if (bus.BUS_REQ) begin
                if (gnt_wait >= gnt_lat) bus.BUS_GNT = 1'b1;
                else gnt_wait++;
            end else if (!bus.BUS_ACK) begin
                bus.BUS_GNT = 1'b0;
                gnt_wait    = 0;
            end

            bus.MEM_RDY   = 1'b0;
            bus.MEM_RDATA = 16'hDEAD;
            if (bus.MEM_RD || bus.MEM_WR) begin
                if (mem_wait >= mem_lat) begin
                    bus.MEM_RDY = 1'b1;
                    mem_wait    = 0;
                    if (bus.MEM_RD) bus.MEM_RDATA = rd_pat(bus.MEM_ADDR);
                end else begin
                    mem_wait++;
                end
            end else begin
                mem_wait = 0;
            end
        end
    end

    // Compare process: bus invariants every busy cycle, and every completed access against the model.
    always @(posedge clk) begin
        acc_t a;
        acc_t e;
        #1;
        cyc++;
        if (nRESET) begin
            if (DMA_START && !DMA_BUSY) start_cyc = cyc;
            if (bus.BUS_REQ) req_seen = 1'b1;
            if (bus.BUS_ACK) ack_seen = 1'b1;
            if (DMA_DONE) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_while_busy", DMA_BUSY, 1'b0);
            end
            if (DMA_BUSY) begin
                busy_cycles++;
                check("strobes_exclusive", bus.MEM_RD & bus.MEM_WR, 1'b0);
                check("strobe_without_ack", (bus.MEM_RD | bus.MEM_WR) & ~bus.BUS_ACK, 1'b0);
                check("req_with_ack", bus.BUS_REQ & bus.BUS_ACK, 1'b0);
            end
            if (bus.MEM_RDY && (bus.MEM_RD || bus.MEM_WR)) begin
                a.wr   = bus.MEM_WR;
                a.addr = bus.MEM_ADDR;
                a.data = bus.MEM_WR ? bus.MEM_WDATA : bus.MEM_RDATA;
                log_q.push_back(a);
                if (bus.MEM_WR) wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_access: got %h expected none", a);
                end else begin
                    e = exp_q.pop_front();
                    check("acc_kind", a.wr, e.wr);
                    check("acc_addr", a.addr, e.addr);
                    if (a.wr) check("acc_wdata", a.data, e.data);
                end
            end
        end
    end

    task automatic start_xfer(input bit mode, input logic [23:0] src, input logic [23:0] dst,
                              input logic [15:0] val, input int cnt, input int ak,
                              input int gl, input int ml);
        int n;
        logic [22:0] s;
        logic [22:0] d;
        n = cnt;
        if (ak > 0 && ak < cnt) n = ak;
        exp_q.delete();
        log_q.delete();
        for (int i = 0; i < n; i++) begin
            s = src[23:1] + 23'(i);
            d = dst[23:1] + 23'(i);
            if (mode) exp_q.push_back({1'b0, s, rd_pat(s)});
            exp_q.push_back({1'b1, d, mode ? rd_pat(s) : val});
        end
        gnt_lat = gl;
        mem_lat = ml;
        abort_k = ak;
        done_cnt = 0; busy_cycles = 0; wr_cnt = 0;
        req_seen = 0; ack_seen = 0; start_cyc = -1; done_cyc = -1;
        @(posedge clk);
        DMA_MODE   = mode;
        DMA_SOURCE = src;
        DMA_DEST   = dst;
        DMA_VALUE  = val;
        DMA_COUNT  = 20'(cnt);
        DMA_START  = 1'b1;
        @(posedge clk);
        DMA_START  = 1'b0;
        // Scramble the config inputs: the engine must work from what it latched.
        DMA_MODE   = 1'($urandom);
        DMA_SOURCE = 24'($urandom);
        DMA_DEST   = 24'($urandom);
        DMA_VALUE  = 16'($urandom);
        DMA_COUNT  = 20'($urandom);
    endtask

    task automatic finish_xfer(input bit spurious);
        bit ended;
        ended = 1'b0;
        for (int t = 0; t < 800 && !ended; t++) begin
            @(posedge clk);
            DMA_START = 1'b0;
            if (spurious && t == 1 && DMA_BUSY) begin
                DMA_START = 1'b1;
                DMA_COUNT = 20'($urandom_range(1, 9));
                DMA_DEST  = 24'($urandom);
            end
            #2;
            if (!DMA_BUSY) ended = 1'b1;
        end
        check("xfer_ended", ended, 1'b1);
        abort_drv = 1'b0;
        abort_k   = 0;
        repeat (2) @(posedge clk);
        #2;
        check("done_pulses", done_cnt, 1);
        check("accesses_left", exp_q.size(), 0);
    endtask

    initial begin
        bit          seen;
        bit          m;
        int          c;
        int          ak;
        logic [23:0] s;
        logic [23:0] d;

        nRESET = 1'b0;
        DMA_START = 1'b0; DMA_MODE = 1'b0; DMA_SOURCE = '0; DMA_DEST = '0;
        DMA_VALUE = '0; DMA_COUNT = '0; abort_drv = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_bus_req", bus.BUS_REQ, 1'b0);
        check("rst_bus_ack", bus.BUS_ACK, 1'b0);
        check("rst_mem_rd", bus.MEM_RD, 1'b0);
        check("rst_mem_wr", bus.MEM_WR, 1'b0);
        check("rst_done", DMA_DONE, 1'b0);
        check("rst_addr", bus.MEM_ADDR, 23'h0);
        check("rst_wdata", bus.MEM_WDATA, 16'h0);
        check("rst_busy", DMA_BUSY, 1'b0);
        @(posedge clk);
        nRESET = 1'b1;

        // Fill of 4 words at 0xE00000, grant one clock after request.
        start_xfer(1'b0, 24'h000000, 24'hE00000, 16'hA5A5, 4, 0, 0, 0);
        finish_xfer(1'b0);
        check("fill_busy_clocks", busy_cycles, 10);
        check("fill_writes", log_q.size(), 4);
        if (log_q.size() == 4) begin
            check("fill_first_addr", log_q[0].addr, 23'h700000);
            check("fill_last_addr", log_q[3].addr, 23'h700003);
            check("fill_data", log_q[2].data, 16'hA5A5);
        end

        // Copy of 3 words, memory answering after 2 clocks.
        start_xfer(1'b1, 24'h100000, 24'hE00000, 16'h0000, 3, 0, 1, 1);
        finish_xfer(1'b0);
        check("copy_accesses", log_q.size(), 6);
        if (log_q.size() == 6) begin
            check("copy_first_is_read", log_q[0].wr, 1'b0);
            check("copy_first_raddr", log_q[0].addr, 23'h080000);
            check("copy_first_waddr", log_q[1].addr, 23'h700000);
            check("copy_first_wdata", log_q[1].data, 16'h115A);
            check("copy_last_waddr", log_q[5].addr, 23'h700002);
            check("copy_last_wdata", log_q[5].data, 16'h1158);
        end

        // Zero count: no bus request, done one clock after the start is taken.
        start_xfer(1'b0, 24'h000000, 24'h123456, 16'h1111, 0, 0, 0, 0);
        finish_xfer(1'b0);
        check("zero_cnt_req", req_seen, 1'b0);
        check("zero_cnt_done_delay", done_cyc - start_cyc, 2);

        // Abort during the 2nd write of 8.
        start_xfer(1'b0, 24'h000000, 24'h200000, 16'h5555, 8, 2, 0, 1);
        finish_xfer(1'b0);
        check("abort_writes", log_q.size(), 2);

        // Destination word-address wrap.
        start_xfer(1'b0, 24'h000000, 24'hFFFFFE, 16'h3C3C, 2, 0, 0, 0);
        finish_xfer(1'b0);
        check("wrap_writes", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("wrap_addr0", log_q[0].addr, 23'h7FFFFF);
            check("wrap_addr1", log_q[1].addr, 23'h000000);
        end

        // Abort while waiting for grant: no access, no BGACK, still one done.
        start_xfer(1'b0, 24'h000000, 24'h300000, 16'h7777, 5, 0, 1000, 0);
        exp_q.delete();
        @(posedge clk);
        abort_drv = 1'b1;
        finish_xfer(1'b0);
        check("req_abort_req_seen", req_seen, 1'b1);
        check("req_abort_ack_seen", ack_seen, 1'b0);
        check("req_abort_accesses", log_q.size(), 0);

        // Start together with abort in IDLE is ignored.
        done_cnt = 0; req_seen = 0;
        @(posedge clk);
        abort_drv = 1'b1; DMA_MODE = 1'b0; DMA_COUNT = 20'd3; DMA_START = 1'b1;
        @(posedge clk);
        DMA_START = 1'b0;
        #2;
        check("start_abort_busy", DMA_BUSY, 1'b0);
        repeat (3) @(posedge clk);
        abort_drv = 1'b0;
        #2;
        check("start_abort_done", done_cnt, 0);
        check("start_abort_req", req_seen, 1'b0);

        // Reset in the middle of a read.
        start_xfer(1'b1, 24'h300000, 24'h400000, 16'h0000, 4, 0, 0, 4);
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(posedge clk);
            #2;
            if (bus.MEM_RD) seen = 1'b1;
        end
        check("rst_mid_rd_seen", seen, 1'b1);
        #1;
        nRESET = 1'b0;
        #1;
        check("rst_mid_rd", bus.MEM_RD, 1'b0);
        check("rst_mid_ack", bus.BUS_ACK, 1'b0);
        check("rst_mid_busy", DMA_BUSY, 1'b0);
        repeat (2) @(posedge clk);
        nRESET = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_mid_done", done_cnt, 0);
        exp_q.delete();

        // Randomized transfers.
        for (int k = 0; k < 40; k++) begin
            m  = 1'($urandom_range(0, 1));
            c  = $urandom_range(1, 6);
            ak = ($urandom_range(0, 3) == 0) ? $urandom_range(1, c) : 0;
            s  = 24'($urandom);
            d  = (k % 5 == 0) ? 24'hFFFFFA : 24'($urandom);
            start_xfer(m, s, d, 16'($urandom), c, ak, $urandom_range(0, 3), $urandom_range(0, 2));
            finish_xfer($urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/cd_dma_engine.md
CD_DMA_ENGINE -- requirements
Module: cd_dma_engine

Interface
REQ-001 Parameter CNT_W, default 20: width of the transfer word counter.
REQ-002 CLK_68KCLK  in  1  system clock; all state changes on its falling edge.
REQ-003 nRESET  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 DMA_START  in  1  one-cycle start pulse, from the FF0061 bit-6 write.
REQ-005 DMA_MODE  in  1  0 = fill (write DMA_VALUE[15:0]), 1 = copy (read source, write dest).
REQ-006 DMA_SOURCE  in  24  source byte address; bit 0 ignored.
REQ-007 DMA_DEST  in  24  destination byte address; bit 0 ignored.
REQ-008 DMA_VALUE  in  16  fill pattern.
REQ-009 DMA_COUNT  in  CNT_W  number of 16-bit words to transfer.
REQ-010 DMA_ABORT  in  1  level; stops the transfer at the next safe point.
REQ-011 BUS_REQ  out  1  bus request to the 68k arbiter (BR).
REQ-012 BUS_GNT  in  1  bus grant (BG); held while the engine owns the bus.
REQ-013 BUS_ACK  out  1  bus grant acknowledge (BGACK).
REQ-014 MEM_ADDR  out  23  word address [23:1].
REQ-015 MEM_WDATA  out  16  write data.
REQ-016 MEM_RDATA  in  16  read data, valid in the cycle MEM_RDY is high.
REQ-017 MEM_RD, MEM_WR  out  1 each  access strobes; mutually exclusive.
REQ-018 MEM_RDY  in  1  access-complete pulse.
REQ-019 DMA_BUSY  out  1  high from accepted start until IDLE is re-entered.
REQ-020 DMA_DONE  out  1  one-cycle pulse when the engine enters IDLE after a started transfer.

Function
REQ-021 States: IDLE, REQ, READ, WRITE, NEXT, RELEASE.
REQ-022 IDLE: on DMA_START, latch all config inputs, go to REQ, and assert BUS_REQ. A latched count of 0 goes straight to RELEASE without requesting the bus.
REQ-023 REQ: wait for BUS_GNT=1, then assert BUS_ACK and go to READ (copy) or WRITE (fill); BUS_REQ drops when BUS_ACK rises.
REQ-024 READ: drive MEM_ADDR=src and MEM_RD until MEM_RDY; capture MEM_RDATA into the data holding register; go to WRITE.
REQ-025 WRITE: drive MEM_ADDR=dst, MEM_WDATA (the holding register or the fill value) and MEM_WR until MEM_RDY; go to NEXT.
REQ-026 NEXT: src+=1 word (copy only), dst+=1 word, count-=1; if the new count is 0 or DMA_ABORT=1, go to RELEASE, else go to READ or WRITE.
REQ-027 Address increments wrap modulo 2^23 words; no carry beyond bit 23.
REQ-028 RELEASE: deassert BUS_ACK and all strobes, pulse DMA_DONE, and return to IDLE in the same transition.
REQ-029 Strobes hold stable until MEM_RDY; an access is never abandoned mid-cycle, including on abort.
REQ-030 DMA_START while DMA_BUSY=1 is ignored; the latched config is unchanged.
REQ-031 DMA_ABORT in REQ before grant: drop BUS_REQ and go to RELEASE, with no memory access.
REQ-032 DMA_START and DMA_ABORT together in IDLE: the start is ignored.
REQ-033 Per-word latency with MEM_RDY returned immediately: fill = 2 clocks, copy = 3 clocks.
REQ-034 DMA_BUSY is combinational from the state, i.e. high whenever the state is not IDLE.

Reset
REQ-035 Async assert forces IDLE, with BUS_REQ=0, BUS_ACK=0, MEM_RD=0, MEM_WR=0, DMA_DONE=0, MEM_ADDR=0, MEM_WDATA=0 and counters at 0.
REQ-036 Reset mid-transfer releases the bus immediately, with no DMA_DONE pulse.
REQ-037 Deassertion is released on a clock edge; the first start is accepted on the edge after deassertion.

Verification
REQ-038 Fill: DMA_DEST=0xE00000, VALUE=0xA5A5, COUNT=4, GNT one clock after REQ -> writes to 0x700000..0x700003 (word), all data 0xA5A5, one DONE pulse, BUSY 10 clocks.
REQ-039 Copy: SRC=0x100000, DEST=0xE00000, COUNT=3, memory model with 2-cycle RDY -> 3 read/write pairs in order, with data matching the source.
REQ-040 COUNT=0 -> BUS_REQ is never asserted, and DONE pulses 1 clock after START.
REQ-041 Abort asserted during the 2nd WRITE of COUNT=8 -> that write completes, RELEASE follows, and exactly 2 writes occur.
REQ-042 nRESET pulled low during READ -> MEM_RD, BUS_ACK and BUSY drop asynchronously, and no DONE pulse occurs.
REQ-043 DEST=0xFFFFFE, COUNT=2 fill -> addresses 0x7FFFFF then 0x000000 (word wrap).
